alu_result_queue: RTL and testbench

//  Downstream collector for the registered ALU unit outputs (arithmetic, logic,

---
 rtl/alu_result_queue.sv | 111 +++++++++++
 tb/tb_alu_result_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_queue.sv
// Collects flagged ALU unit results, tags them by source and queues them
// in a show-ahead FIFO drained over a valid/ready handshake.
module alu_result_queue #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] Arith_Out,
  input  logic             Arith_Flag,
  input  logic [WIDTH-1:0] Logic_Out,
  input  logic             Logic_Flag,
  input  logic [WIDTH-1:0] CMP_Out,
  input  logic             CMP_Flag,
  input  logic [WIDTH-1:0] SHIFT_Out,
  input  logic             SHIFT_Flag,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             collision
);

  logic [WIDTH+1:0] mem [DEPTH];
  logic [WIDTH+1:0] head_q;
  logic [WIDTH+1:0] wdata;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_next;
  logic [CW-1:0]    cnt_next;
  logic [1:0]       sel_tag;
  logic [WIDTH-1:0] sel_data;
  logic [2:0]       n_flags;
  logic             push;
  logic             pop;
  logic             full;
  logic             accept;

  always_comb begin
    sel_tag  = 2'b00;
    sel_data = Arith_Out;
    if (Arith_Flag) begin
      sel_tag  = 2'b00;
      sel_data = Arith_Out;
    end else if (Logic_Flag) begin
      sel_tag  = 2'b01;
      sel_data = Logic_Out;
    end else if (CMP_Flag) begin
      sel_tag  = 2'b10;
      sel_data = CMP_Out;
    end else if (SHIFT_Flag) begin
      sel_tag  = 2'b11;
      sel_data = SHIFT_Out;
    end
  end

  assign n_flags = {2'b00, Arith_Flag} + {2'b00, Logic_Flag}
                 + {2'b00, CMP_Flag} + {2'b00, SHIFT_Flag};

  assign push      = Arith_Flag | Logic_Flag | CMP_Flag | SHIFT_Flag;
  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign pop       = out_valid & out_ready;
  assign accept    = push & (~full | pop);
  assign wdata     = {sel_tag, sel_data};
  assign rd_next   = pop ? rd_ptr + AW'(1) : rd_ptr;

  always_comb begin
    cnt_next = count;
    if (accept && !pop)
      cnt_next = count + CW'(1);
    else if (!accept && pop)
      cnt_next = count - CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (accept)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      head_q    <= '0;
      overflow  <= 1'b0;
      collision <= 1'b0;
    end else begin
      rd_ptr <= rd_next;
      count  <= cnt_next;
      if (accept)
        wr_ptr <= wr_ptr + AW'(1);
      // New head is the incoming word only when it lands on the read slot
      if (cnt_next != '0)
        head_q <= (accept && wr_ptr == rd_next) ? wdata : mem[rd_next];
      if (push && full && !pop)
        overflow <= 1'b1;
      if (n_flags > 3'd1)
        collision <= 1'b1;
    end
  end

  assign out_data = head_q[WIDTH-1:0];
  assign out_tag  = head_q[WIDTH+1:WIDTH];

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed self-checking bench for alu_result_queue.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_alu_result_queue;

  logic        CLK;
  logic        RST;
  logic [15:0] Arith_Out;
  logic        Arith_Flag;
  logic [15:0] Logic_Out;
  logic        Logic_Flag;
  logic [15:0] CMP_Out;
  logic        CMP_Flag;
  logic [15:0] SHIFT_Out;
  logic        SHIFT_Flag;
  logic [15:0] out_data;
  logic [1:0]  out_tag;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;
  logic        overflow;
  logic        collision;

  int n_checks = 0;
  int n_errors = 0;

  logic [17:0] q[$];

  alu_result_queue #(.WIDTH(16), .DEPTH(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .Arith_Out(Arith_Out),
    .Arith_Flag(Arith_Flag),
    .Logic_Out(Logic_Out),
    .Logic_Flag(Logic_Flag),
    .CMP_Out(CMP_Out),
    .CMP_Flag(CMP_Flag),
    .SHIFT_Out(SHIFT_Out),
    .SHIFT_Flag(SHIFT_Flag),
    .out_data(out_data),
    .out_tag(out_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count(count),
    .overflow(overflow),
    .collision(collision)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int src, input logic [15:0] d);
    Arith_Flag = 1'b0;
    Logic_Flag = 1'b0;
    CMP_Flag   = 1'b0;
    SHIFT_Flag = 1'b0;
    Arith_Out  = ~d;
    Logic_Out  = ~d;
    CMP_Out    = ~d;
    SHIFT_Out  = ~d;
    case (src)
      0: begin Arith_Flag = 1'b1; Arith_Out = d; end
      1: begin Logic_Flag = 1'b1; Logic_Out = d; end
      2: begin CMP_Flag   = 1'b1; CMP_Out   = d; end
      3: begin SHIFT_Flag = 1'b1; SHIFT_Out = d; end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    drive(4, 16'h0);
    out_ready = 1'b0;
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic model_cycle(input int src,
                             input logic [15:0] d,
                             input logic rdy);
    bit pop_m;
    bit acc_m;
    logic [1:0] t;
    drive(src, d);
    out_ready = rdy;
    pop_m = (q.size() != 0) && rdy;
    acc_m = (src < 4) && ((q.size() < 4) || pop_m);
    t = src[1:0];
    step();
    if (pop_m) void'(q.pop_front());
    if (acc_m) q.push_back({t, d});
    check("m_count", 32'(count), 32'(q.size()));
    check("m_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("m_data", 32'(out_data), 32'(q[0][15:0]));
      check("m_tag", 32'(out_tag), 32'(q[0][17:16]));
    end
  endtask

  int          src_t [10] = '{0, 1, 2, 3, 0, 1, 4, 2, 3, 0};
  logic [15:0] dat_t [10] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004,
                              16'hA005, 16'hA006, 16'h0000, 16'hA008,
                              16'hA009, 16'hA00A};
  bit          rdy_t [10] = '{0, 0, 1, 1, 0, 1, 1, 0, 1, 1};

  logic [15:0] exp_d [4];
  logic [1:0]  exp_t [4];

  initial begin
    RST = 1'b1;
    out_ready = 1'b0;
    drive(4, 16'h0);

    do_reset();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_col", 32'(collision), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_tag", 32'(out_tag), 0);

    drive(1, 16'h00F0);
    step();
    drive(4, 16'h0);
    check("single_valid", 32'(out_valid), 1);
    check("single_data", 32'(out_data), 32'h00F0);
    check("single_tag", 32'(out_tag), 1);
    check("single_count", 32'(count), 1);
    step();
    check("stall_valid", 32'(out_valid), 1);
    check("stall_data", 32'(out_data), 32'h00F0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("drain_count", 32'(count), 0);
    check("drain_valid", 32'(out_valid), 0);
    check("hold_data", 32'(out_data), 32'h00F0);

    for (int i = 1; i <= 5; i++) begin
      drive(0, 16'(i));
      step();
      check("fill_count", 32'(count), (i > 4) ? 4 : i);
      check("fill_ovf", 32'(overflow), (i > 4) ? 1 : 0);
    end
    drive(4, 16'h0);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("fill_data", 32'(out_data), i);
      check("fill_tag", 32'(out_tag), 0);
      step();
    end
    out_ready = 1'b0;
    check("fill_empty", 32'(count), 0);
    check("ovf_sticky", 32'(overflow), 1);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 16'h0010 + 16'(i));
      step();
    end
    check("full_count", 32'(count), 4);
    drive(3, 16'hABCD);
    out_ready = 1'b1;
    step();
    drive(4, 16'h0);
    check("fs_count", 32'(count), 4);
    check("fs_ovf", 32'(overflow), 0);
    exp_d = '{16'h0011, 16'h0012, 16'h0013, 16'hABCD};
    exp_t = '{2'd0, 2'd0, 2'd0, 2'd3};
    for (int i = 0; i < 4; i++) begin
      check("fs_data", 32'(out_data), 32'(exp_d[i]));
      check("fs_tag", 32'(out_tag), 32'(exp_t[i]));
      step();
    end
    out_ready = 1'b0;
    check("fs_empty", 32'(count), 0);

    do_reset();
    Arith_Out  = 16'h1111;
    Arith_Flag = 1'b1;
    CMP_Out    = 16'h2222;
    CMP_Flag   = 1'b1;
    step();
    drive(4, 16'h0);
    check("col_count", 32'(count), 1);
    check("col_data", 32'(out_data), 32'h1111);
    check("col_tag", 32'(out_tag), 0);
    check("col_flag", 32'(collision), 1);
    step();
    check("col_sticky", 32'(collision), 1);

    do_reset();
    q.delete();
    for (int i = 0; i < 10; i++)
      model_cycle(src_t[i], dat_t[i], rdy_t[i]);
    for (int k = 0; k < 8 && q.size() != 3; k++) begin
      if (q.size() < 3) model_cycle(0, 16'hB000 + 16'(k), 1'b0);
      else model_cycle(4, 16'h0, 1'b1);
    end
    check("pre_rst_count", 32'(count), 3);
    drive(4, 16'h0);
    out_ready = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    q.delete();
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_ovf", 32'(overflow), 0);
    model_cycle(1, 16'h5A5A, 1'b0);
    check("post_rst_data", 32'(out_data), 32'h5A5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
